coef_bitstream_encoder: RTL and testbench

Lossless entropy encoder: the writer counterpart of the milestone-3 bitstream decoder. Consumes quantized DCT coefficients, 64 per 8x8 block, already in scan order, over a valid/ready stream. Encodes them with the fixed variable-length code below, packs the codes MSB-first into 16-bit words, and writes those words to SRAM from `BITSTREAM_OFFSET` upward. Used to generate bit-exact compressed images for decoder verification, and by the reverse (compression) datapath.

---
 rtl/coef_bitstream_encoder_pkg.sv | 34 +++
 rtl/coef_bitstream_encoder_if.sv | 23 ++
 rtl/coef_bitstream_encoder_packer.sv | 78 +++++++
 rtl/coef_bitstream_encoder.sv | 159 +++++++++++++++
 tb/tb_coef_bitstream_encoder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/coef_bitstream_encoder_pkg.sv
// encoder_pkg: shared types and code-table constants for the coefficient
// bitstream encoder (FSM states, code prefixes and lengths, block geometry).
package encoder_pkg;

   localparam int DATA_W      = 16;
   localparam int ADDR_W      = 18;
   localparam int WORD_W      = 16;
   localparam int CODE_W      = 11;
   localparam int RUN_MAX     = 8;
   localparam int BLOCK_COEFS = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_EMIT_RUN,
      S_EMIT_VAL,
      S_EMIT_EOB,
      S_FLUSH,
      S_DONE
   } state_t;

   localparam logic [1:0] PFX_SMALL = 2'b00;
   localparam logic [1:0] PFX_MED   = 2'b01;
   localparam logic [1:0] PFX_LARGE = 2'b10;
   localparam logic [2:0] PFX_RUN   = 3'b111;
   localparam logic [2:0] CODE_EOB  = 3'b110;

   localparam logic [3:0] LEN_SMALL = 4'd5;
   localparam logic [3:0] LEN_MED   = 4'd8;
   localparam logic [3:0] LEN_LARGE = 4'd11;
   localparam logic [3:0] LEN_RUN   = 4'd6;
   localparam logic [3:0] LEN_EOB   = 4'd3;

endpackage

// File: rtl/coef_bitstream_encoder_if.sv
// Coefficient stream (valid/ready) and SRAM write port of the encoder.
// master = coefficient source / SRAM owner, slave = the encoder.
interface coef_bitstream_encoder_if;
   import encoder_pkg::*;

   logic signed [DATA_W-1:0] coef_data;
   logic                     coef_valid;
   logic                     coef_ready;
   logic [ADDR_W-1:0]        SRAM_address;
   logic [WORD_W-1:0]        SRAM_write_data;
   logic                     SRAM_we_n;

   modport master (
      output coef_data, coef_valid,
      input  coef_ready, SRAM_address, SRAM_write_data, SRAM_we_n
   );

   modport slave (
      input  coef_data, coef_valid,
      output coef_ready, SRAM_address, SRAM_write_data, SRAM_we_n
   );

endinterface

// File: rtl/coef_bitstream_encoder_packer.sv
// bitstream_packer: MSB-first bit accumulator feeding 16-bit SRAM words.
// A word is written whenever 16 or more bits are pending; in flush mode a
// partial word is written left-aligned and zero-padded.
module bitstream_packer
   import encoder_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BITSTREAM_OFFSET = 18'd76800
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CODE_W-1:0] code,
   input  logic [3:0]        len,
   input  logic              append,
   input  logic              flush,
   output logic              flush_done,
   output logic [ADDR_W-1:0] sram_address,
   output logic [WORD_W-1:0] sram_write_data,
   output logic              sram_we_n
);

   logic [31:0]       acc_p0;
   logic [4:0]        cnt_p0;
   logic [ADDR_W-1:0] next_addr;

   logic [31:0]       acc_drain, acc_next;
   logic [4:0]        cnt_drain, cnt_next;
   logic [CODE_W-1:0] code_la;
   logic              wr;

   assign flush_done = (cnt_p0 == 5'd0);

   // drain one word if available, then merge the new code below the pending bits
   always_comb begin
      acc_drain = acc_p0;
      cnt_drain = cnt_p0;
      wr        = 1'b0;
      if (cnt_p0 >= 5'd16) begin
         wr        = 1'b1;
         acc_drain = acc_p0 << 16;
         cnt_drain = cnt_p0 - 5'd16;
      end else if (flush && cnt_p0 != 5'd0) begin
         wr        = 1'b1;
         acc_drain = '0;
         cnt_drain = '0;
      end
      code_la  = code << (4'(CODE_W) - len);
      acc_next = acc_drain;
      cnt_next = cnt_drain;
      if (append) begin
         acc_next = acc_drain | ({code_la, 21'd0} >> cnt_drain);
         cnt_next = cnt_drain + {1'b0, len};
      end
   end

   // stage p0 -> SRAM port: accumulator update and registered write strobe/address/data
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0          <= '0;
         cnt_p0          <= '0;
         next_addr       <= BITSTREAM_OFFSET;
         sram_address    <= '0;
         sram_write_data <= '0;
         sram_we_n       <= 1'b1;
      end else begin
         acc_p0 <= acc_next;
         cnt_p0 <= cnt_next;
         if (wr) begin
            sram_we_n       <= 1'b0;
            sram_address    <= next_addr;
            sram_write_data <= acc_p0[31:16];
            next_addr       <= next_addr + 1'b1;
         end else begin
            sram_we_n <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/coef_bitstream_encoder.sv
// coef_bitstream_encoder: variable-length encoder for scan-ordered 8x8 DCT
// coefficient blocks, packed MSB-first into 16-bit SRAM words.
// Build option: define ENCODER_SATURATE_EN to clamp inputs to -256..255;
// otherwise the low 9 bits are taken as a signed value (wraps).
module coef_bitstream_encoder
   import encoder_pkg::*;
#(
   parameter int                NUM_BLOCKS       = 2400,
   parameter logic [ADDR_W-1:0] BITSTREAM_OFFSET = 18'd76800
) (
   input  logic Clock_50,
   input  logic Reset,
   input  logic milestone_start,
   output logic milestone_done,
   coef_bitstream_encoder_if.slave bus
);

   localparam int BLK_W = $clog2(NUM_BLOCKS + 1);

   function automatic logic signed [8:0] clamp9(input logic signed [DATA_W-1:0] x);
`ifdef ENCODER_SATURATE_EN
      if (x > 16'sd255)       return 9'sh0FF;
      else if (x < -16'sd256) return 9'sh100;
      else                    return 9'(x);
`else
      return 9'(x);
`endif
   endfunction

   state_t            state_p0, state_nxt;
   logic [5:0]        idx_p0;
   logic [5:0]        zcnt_p0;
   logic [5:0]        run_p0;
   logic              eob_p0;
   logic [BLK_W-1:0]  blk_p0;
   logic signed [8:0] val_p0;

   logic              xfer, is_zero, last_idx, last_blk;
   logic signed [8:0] v_in;
   logic [3:0]        run_len;
   logic [CODE_W-1:0] code;
   logic [3:0]        len;
   logic              append, flush, flush_done;

   assign bus.coef_ready = (state_p0 == S_ACCEPT);
   assign xfer           = bus.coef_valid && (state_p0 == S_ACCEPT);
   assign v_in           = clamp9(bus.coef_data);
   assign is_zero        = (v_in == 9'sd0);
   assign last_idx       = (idx_p0 == 6'(BLOCK_COEFS - 1));
   assign last_blk       = (blk_p0 == BLK_W'(NUM_BLOCKS - 1));
   assign run_len        = (run_p0 > 6'(RUN_MAX)) ? 4'(RUN_MAX) : run_p0[3:0];

   // next state and the code appended by the current emit state
   always_comb begin
      state_nxt = state_p0;
      code      = '0;
      len       = '0;
      append    = 1'b0;
      flush     = 1'b0;
      case (state_p0)
         S_IDLE:
            if (milestone_start && !milestone_done) state_nxt = S_ACCEPT;
         S_ACCEPT:
            if (xfer) begin
               if (!is_zero)      state_nxt = (zcnt_p0 != 6'd0) ? S_EMIT_RUN : S_EMIT_VAL;
               else if (last_idx) state_nxt = S_EMIT_EOB;
            end
         S_EMIT_RUN: begin
            append = 1'b1;
            code   = {5'd0, PFX_RUN, 3'(run_len - 4'd1)};
            len    = LEN_RUN;
            if (run_p0 <= 6'(RUN_MAX)) state_nxt = S_EMIT_VAL;
         end
         S_EMIT_VAL: begin
            append = 1'b1;
            if (val_p0 >= -9'sd4 && val_p0 <= 9'sd3) begin
               code = {6'd0, PFX_SMALL, val_p0[2:0]};
               len  = LEN_SMALL;
            end else if (val_p0 >= -9'sd32 && val_p0 <= 9'sd31) begin
               code = {3'd0, PFX_MED, val_p0[5:0]};
               len  = LEN_MED;
            end else begin
               code = {PFX_LARGE, val_p0};
               len  = LEN_LARGE;
            end
            state_nxt = eob_p0 ? S_EMIT_EOB : S_ACCEPT;
         end
         S_EMIT_EOB: begin
            append    = 1'b1;
            code      = {8'd0, CODE_EOB};
            len       = LEN_EOB;
            state_nxt = last_blk ? S_FLUSH : S_ACCEPT;
         end
         S_FLUSH: begin
            flush = 1'b1;
            if (flush_done) state_nxt = S_DONE;
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge Clock_50) begin
      if (Reset) state_p0 <= S_IDLE;
      else       state_p0 <= state_nxt;
   end

   // control counters: a zero run is only counted here and expanded into
   // RUN codes when a nonzero follows, so a trailing run is absorbed by EOB
   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         idx_p0         <= '0;
         zcnt_p0        <= '0;
         run_p0         <= '0;
         eob_p0         <= 1'b0;
         blk_p0         <= '0;
         milestone_done <= 1'b0;
      end else begin
         if (xfer) begin
            idx_p0 <= idx_p0 + 6'd1;
            if (!is_zero) begin
               run_p0  <= zcnt_p0;
               eob_p0  <= last_idx;
               zcnt_p0 <= '0;
            end else if (last_idx) begin
               eob_p0  <= 1'b1;
               zcnt_p0 <= '0;
            end else begin
               zcnt_p0 <= zcnt_p0 + 6'd1;
            end
         end
         if (state_p0 == S_EMIT_RUN) run_p0 <= run_p0 - {2'b00, run_len};
         if (state_p0 == S_EMIT_EOB) blk_p0 <= blk_p0 + 1'b1;
         if (state_p0 == S_FLUSH && flush_done) milestone_done <= 1'b1;
      end
   end

   // stage p0: captured coefficient value for the value code
   always_ff @(posedge Clock_50) begin
      if (xfer && !is_zero) val_p0 <= v_in;
   end

   bitstream_packer #(
      .BITSTREAM_OFFSET(BITSTREAM_OFFSET)
   ) u_packer (
      .clk             (Clock_50),
      .rst             (Reset),
      .code            (code),
      .len             (len),
      .append          (append),
      .flush           (flush),
      .flush_done      (flush_done),
      .sram_address    (bus.SRAM_address),
      .sram_write_data (bus.SRAM_write_data),
      .sram_we_n       (bus.SRAM_we_n)
   );

endmodule

// File: tb/tb_coef_bitstream_encoder.sv
// Directed bench for coef_bitstream_encoder with NUM_BLOCKS=1.
module tb_coef_bitstream_encoder;

   localparam logic [17:0] OFF = 18'd76800;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic done;
   logic clr;

   coef_bitstream_encoder_if bus();

   coef_bitstream_encoder #(
      .NUM_BLOCKS       (1),
      .BITSTREAM_OFFSET (OFF)
   ) dut (
      .Clock_50        (clk),
      .Reset           (rst),
      .milestone_start (start),
      .milestone_done  (done),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // SRAM model
   logic [15:0] img [16];
   logic [15:0] ref_img [5];
   int          wr_cnt;
   int          oor;

   always @(posedge clk) begin
      if (clr) begin
         wr_cnt <= 0;
         oor    <= 0;
         for (int i = 0; i < 16; i++) img[i] <= 16'hDEAD;
      end else if (bus.SRAM_we_n === 1'b0) begin
         wr_cnt <= wr_cnt + 1;
         if (bus.SRAM_address >= OFF && bus.SRAM_address < OFF + 18'd16)
            img[4'(bus.SRAM_address - OFF)] <= bus.SRAM_write_data;
         else
            oor <= oor + 1;
      end
   end

   logic signed [15:0] blk [64];

   task automatic blk_zero();
      for (int i = 0; i < 64; i++) blk[i] = 16'sd0;
   endtask

   task automatic send(input logic signed [15:0] v, input int idx);
      int t;
      t = 0;
      bus.coef_data  = v;
      bus.coef_valid = 1'b1;
      while (bus.coef_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check_eq("ready_timeout", t, 0);
      @(negedge clk);
      bus.coef_valid = 1'b0;
      check_eq($sformatf("ready_after_%0d", idx), bus.coef_ready, (v == 0 && idx != 63) ? 1 : 0);
   endtask

   task automatic send_block(input int ncoef, input bit drops);
      for (int i = 0; i < ncoef; i++) begin
         if (drops && $urandom_range(0, 2) == 0) begin
            bus.coef_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send(blk[i], i);
      end
   endtask

   task automatic do_reset_clear();
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b1;
      clr   = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check_eq("rst_we_n", bus.SRAM_we_n, 1);
      check_eq("rst_ready", bus.coef_ready, 0);
      check_eq("rst_done", done, 0);
      rst = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int cyc, last_wr;
      cyc = 0;
      last_wr = -10;
      while (done !== 1'b1 && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.SRAM_we_n === 1'b0) last_wr = cyc;
      end
      check_eq({tag, "_done"}, done, 1);
      check_eq({tag, "_done_lat"}, cyc - last_wr, 1);
   endtask

   task automatic run_scn(input string tag, input bit drops);
      do_reset_clear();
      start = 1'b1;
      send_block(64, drops);
      wait_done(tag);
   endtask

   task automatic load_vec_b();
      blk_zero();
      blk[0]  = -16'sd4;
      blk[1]  = 16'sd3;
      blk[2]  = 16'sd4;
      blk[3]  = -16'sd32;
      blk[20] = -16'sd33;
      blk[22] = -16'sd5;
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      clr = 1'b1;
      bus.coef_valid = 1'b0;
      bus.coef_data = '0;
      @(negedge clk);
      @(negedge clk);
      clr = 1'b0;
      check_eq("init_addr", bus.SRAM_address, 0);
      check_eq("init_data", bus.SRAM_write_data, 0);
      check_eq("init_we_n", bus.SRAM_we_n, 1);
      check_eq("init_ready", bus.coef_ready, 0);
      check_eq("init_done", done, 0);
      rst = 1'b0;
      @(negedge clk);
      check_eq("idle_ready", bus.coef_ready, 0);

      // all zeros: EOB only
      blk_zero();
      run_scn("zeros", 1'b0);
      check_eq("zeros_cnt", wr_cnt, 1);
      check_eq("zeros_w0", img[0], 16'hC000);
      check_eq("zeros_w1", img[1], 16'hDEAD);
      check_eq("zeros_oor", oor, 0);
      repeat (3) @(negedge clk);
      check_eq("held_done", done, 1);
      check_eq("held_ready", bus.coef_ready, 0);
      check_eq("held_we_n", bus.SRAM_we_n, 1);

      // small value then trailing zeros
      blk_zero();
      blk[0] = 16'sd3;
      run_scn("small", 1'b0);
      check_eq("small_cnt", wr_cnt, 1);
      check_eq("small_w0", img[0], 16'h1E00);

      // RUN(2), small -1, EOB
      blk_zero();
      blk[2] = -16'sd1;
      run_scn("neg", 1'b0);
      check_eq("neg_cnt", wr_cnt, 1);
      check_eq("neg_w0", img[0], 16'hE4F8);

      // RUN(8), RUN(1), medium 5
      blk_zero();
      blk[9] = 16'sd5;
      run_scn("run9", 1'b0);
      check_eq("run9_cnt", wr_cnt, 2);
      check_eq("run9_w0", img[0], 16'hFF84);
      check_eq("run9_w1", img[1], 16'h5C00);

      // out-of-range value
      blk_zero();
      blk[0] = 16'sd300;
      run_scn("big", 1'b0);
      check_eq("big_cnt", wr_cnt, 1);
`ifdef ENCODER_SATURATE_EN
      check_eq("big_w0", img[0], 16'h9FF8);
`else
      check_eq("big_w0", img[0], 16'hA598);
`endif

      // mixed block, uninterrupted
      load_vec_b();
      run_scn("mix", 1'b0);
      check_eq("mix_cnt", wr_cnt, 5);
      check_eq("mix_w0", img[0], 16'h20D1);
      check_eq("mix_w1", img[1], 16'h183F);
      check_eq("mix_w2", img[2], 16'hFEEF);
      check_eq("mix_w3", img[3], 16'hF0F7);
      check_eq("mix_w4", img[4], 16'h8000);
      for (int i = 0; i < 5; i++) ref_img[i] = img[i];

      // mixed block with valid gaps, reset after 10 coefficients, restart
      do_reset_clear();
      start = 1'b1;
      send_block(10, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_we_n", bus.SRAM_we_n, 1);
      check_eq("mid_rst_ready", bus.coef_ready, 0);
      check_eq("mid_rst_done", done, 0);
      rst = 1'b0;
      send_block(64, 1'b1);
      wait_done("restart");
      for (int i = 0; i < 5; i++)
         check_eq($sformatf("restart_w%0d", i), img[i], ref_img[i]);
      check_eq("restart_w5", img[5], 16'hDEAD);
      check_eq("restart_oor", oor, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
